// File: rtl/rst_seq_gen.sv
// Reset sequence generator: four-phase req/ack handshake driving a registered active-low reset.
// Optional req glitch filter in IDLE is compiled in with RST_SEQ_REQ_FILTER_EN.
module rst_seq_gen #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic       ack,
  output logic       rst_out_n,
  output logic       busy,
  output logic [7:0] rst_count
);

  localparam int unsigned MAXC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_L   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] SETTLE_L = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] ONE_L    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SETTLE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          por_q, por_d;
  logic [7:0]    rst_count_q, rst_count_d;
  logic          rst_out_n_q, rst_out_n_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          accept;

`ifdef RST_SEQ_REQ_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

  logic [FW-1:0] filt_q, filt_d;

  // Counts consecutive high samples in IDLE; any low sample or other state clears it.
  always_comb begin
    filt_d = '0;
    accept = 1'b0;
    if (state_q == IDLE && req) begin
      if (filt_q == FILT_LAST) begin
        accept = 1'b1;
      end else begin
        filt_d = filt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  always_comb begin
    accept = req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    por_d       = por_q;
    rst_count_d = rst_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ASSERT;
          cnt_d   = HOLD_L;
        end
      end
      ASSERT: begin
        if (cnt_q == ONE_L) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_L;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == ONE_L) begin
          if (por_q) begin
            state_d = IDLE;
            por_d   = 1'b0;
          end else if (req) begin
            state_d = DONE;
            if (rst_count_q != 8'hFF) begin
              rst_count_d = rst_count_q + 8'd1;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register on the transition edge.
    rst_out_n_d = (state_d != ASSERT);
    ack_d       = (state_d == DONE);
    busy_d      = (state_d == ASSERT) || (state_d == SETTLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ASSERT;
      cnt_q       <= HOLD_L;
      por_q       <= 1'b1;
      rst_count_q <= '0;
      rst_out_n_q <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      por_q       <= por_d;
      rst_count_q <= rst_count_d;
      rst_out_n_q <= rst_out_n_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign rst_out_n = rst_out_n_q;
  assign busy      = busy_q;
  assign rst_count = rst_count_q;

endmodule
